// File: rtl/alu_seq_ctrl.sv
// Sequenced ALU: valid/ready request in, valid/ready result out. Logic and arithmetic ops take one
// execute cycle; shifts iterate one bit per cycle. Results can be chained through an accumulator.
module alu_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSrl = 3'b110;
  localparam logic [2:0] OpSra = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             shc_q, shc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             is_shift;
  logic             out_hs;

  assign is_shift  = op[2] & (op[1] | op[0]);
  assign out_hs    = (state_q == StDone) & out_ready;
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = res_q;
  assign zero      = z_q;
  assign negative  = n_q;
  assign carry     = c_q;
  assign overflow  = v_q;

  // Single-cycle datapath for the non-shift ops, fed from the latched request.
  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op_q)
      OpAdd: begin
        sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) & (alu_res[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OpSub: begin
        // Carry out of A + ~B + 1 is the no-borrow flag.
        sum_ext = {1'b0, opa_q} + {1'b0, ~opb_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) & (alu_res[WIDTH-1] != opa_q[WIDTH-1]);
      end
      OpAnd:   alu_res = opa_q & opb_q;
      OpOr:    alu_res = opa_q | opb_q;
      OpXor:   alu_res = opa_q ^ opb_q;
      default: alu_res = opa_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    shc_d   = shc_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          opa_d   = acc_mode ? acc_q : a;
          opb_d   = b;
          cnt_d   = b[SHW-1:0];
          shc_d   = 1'b0;
          state_d = is_shift ? StShift : StExec;
        end
      end
      StExec: begin
        res_d   = alu_res;
        c_d     = alu_c;
        v_d     = alu_v;
        z_d     = (alu_res == '0);
        n_d     = alu_res[WIDTH-1];
        state_d = StDone;
      end
      StShift: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SHW'(1);
          unique case (op_q)
            OpSll: begin
              shc_d = opa_q[WIDTH-1];
              opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end
            OpSra: begin
              shc_d = opa_q[0];
              opa_d = {opa_q[WIDTH-1], opa_q[WIDTH-1:1]};
            end
            default: begin
              shc_d = opa_q[0];
              opa_d = {1'b0, opa_q[WIDTH-1:1]};
            end
          endcase
        end else begin
          res_d   = opa_q;
          c_d     = shc_q;
          v_d     = 1'b0;
          z_d     = (opa_q == '0);
          n_d     = opa_q[WIDTH-1];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear takes priority over loading a handed-off result.
  always_comb begin
    acc_d = acc_q;
    if (out_hs)  acc_d = res_q;
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      shc_q   <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      shc_q   <= shc_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed results, flags and latencies for WIDTH=8.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       acc_mode, acc_clr;
  logic       out_valid, out_ready;
  logic [7:0] result;
  logic       zero, negative, carry, overflow, busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(8), .SHW(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .acc_mode (acc_mode),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for out_valid, check latency/result/flags; leaves DUT in DONE.
  task automatic issue(input string tag, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic am, input int exp_lat,
                       input logic [7:0] er, input logic [3:0] ezncv);
    int waits;
    int lat;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(posedge clk); #1; waits++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = av; b = bv; acc_mode = am;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hEE; b = 8'hEE; acc_mode = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " ZNCV"}, 32'({zero, negative, carry, overflow}), 32'(ezncv));
  endtask

  task automatic handshake(input string tag, input logic clr);
    out_ready = 1'b1; acc_clr = clr;
    @(posedge clk); #1;
    out_ready = 1'b0; acc_clr = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    #23;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a 7-step SLL.
    in_valid = 1'b1; op = 3'b101; a = 8'hAA; b = 8'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid-shift busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #2;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort no result", 32'(out_valid), 32'd0);

    issue("add 1+1", 3'b000, 8'h01, 8'h01, 1'b0, 2, 8'h02, 4'b0000);
    handshake("add 1+1", 1'b0);
    issue("add 7f+1", 3'b000, 8'h7F, 8'h01, 1'b0, 2, 8'h80, 4'b0101);
    handshake("add 7f+1", 1'b0);
    issue("add ff+1", 3'b000, 8'hFF, 8'h01, 1'b0, 2, 8'h00, 4'b1010);
    handshake("add ff+1", 1'b0);
    issue("sub 5-7", 3'b001, 8'h05, 8'h07, 1'b0, 2, 8'hFE, 4'b0100);
    handshake("sub 5-7", 1'b0);
    issue("sub 80-1", 3'b001, 8'h80, 8'h01, 1'b0, 2, 8'h7F, 4'b0011);
    handshake("sub 80-1", 1'b0);
    issue("and", 3'b010, 8'hF0, 8'h3C, 1'b0, 2, 8'h30, 4'b0000);
    handshake("and", 1'b0);
    issue("or", 3'b011, 8'h81, 8'h02, 1'b0, 2, 8'h83, 4'b0100);
    handshake("or", 1'b0);
    issue("sra 90>>3", 3'b111, 8'h90, 8'h03, 1'b0, 5, 8'hF2, 4'b0100);
    handshake("sra", 1'b0);
    issue("sll 81<<1", 3'b101, 8'h81, 8'h01, 1'b0, 3, 8'h02, 4'b0010);
    handshake("sll", 1'b0);
    issue("srl b=0", 3'b110, 8'h5A, 8'h00, 1'b0, 2, 8'h5A, 4'b0000);
    handshake("srl0", 1'b0);
    issue("srl 81>>2", 3'b110, 8'h81, 8'h02, 1'b0, 4, 8'h20, 4'b0000);
    handshake("srl2", 1'b0);

    // Accumulator chain; the clear coincides with the second handshake.
    issue("acc seed", 3'b000, 8'h10, 8'h20, 1'b0, 2, 8'h30, 4'b0000);
    handshake("acc seed", 1'b0);
    issue("acc+5", 3'b000, 8'h00, 8'h05, 1'b1, 2, 8'h35, 4'b0000);
    handshake("acc+5", 1'b1);
    issue("acc cleared+1", 3'b000, 8'h77, 8'h01, 1'b1, 2, 8'h01, 4'b0000);
    handshake("acc cleared", 1'b0);

    // Backpressure on an XOR result.
    issue("xor", 3'b100, 8'hF0, 8'hFF, 1'b0, 2, 8'h0F, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold result", 32'(result), 32'h0F);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    handshake("xor", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
